// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings and the decoded control bundle for the RV32I
// pipeline registers.
//   - result_src / alu_op encodings as driven by the control unit
//   - major opcode constants
//   - ctrl_t: control bundle carried from decode to execute; CTRL_NOP is the
//     all-zero bubble (no register write, no store, no jump, no branch)
package pipe_pkg;

    localparam logic [1:0] RES_ALU     = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_PC4     = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Fields are plain logic (not enums) so unknown control values from the
    // decoder pass through untouched.
    typedef struct packed {
        logic [1:0] result_src;
        logic       mem_write;
        logic       reg_write;
        logic       jmp;
        logic       branch;
        logic [1:0] alu_op;
        logic       alu_src;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: generic pipeline field register.
//   i_clk  clock (rising edge)
//   i_rst  asynchronous active-high reset, clears to 0
//   i_clr  synchronous clear (bubble load), wins over i_en
//   i_en   load enable; 0 holds the current value
//   i_d    next value, o_q registered value
module pipe_field_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (i_clr)
            val_d = '0;
        else if (i_en)
            val_d = i_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            val_q <= '0;
        else
            val_q <= val_d;
    end

    assign o_q = val_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register of the 5-stage RV32I pipeline.
//   i_clk, i_rst        clock, asynchronous active-high reset (all outputs 0)
//   i_en, i_flush       load / hold, bubble insertion (flush wins over en)
//   i_*_d               decoded control, funct bits, operands, PC values and
//                       register addresses from the decode stage
//   o_*_e               registered copies for the execute stage
//   o_valid_e           execute-stage instruction is real
//   o_bubble_cnt        real instructions squashed by flush since reset
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic             i_valid_d,
    input  logic [1:0]       i_result_src_d,
    input  logic             i_mem_write_d,
    input  logic             i_reg_write_d,
    input  logic             i_jmp_d,
    input  logic             i_branch_d,
    input  logic [1:0]       i_alu_op_d,
    input  logic             i_alu_src_d,
    input  logic [2:0]       i_funct3_d,
    input  logic             i_funct7b5_d,
    input  logic [XLEN-1:0]  i_rd1_d,
    input  logic [XLEN-1:0]  i_rd2_d,
    input  logic [XLEN-1:0]  i_pc_d,
    input  logic [XLEN-1:0]  i_pc_plus4_d,
    input  logic [XLEN-1:0]  i_imm_ext_d,
    input  logic [RA_W-1:0]  i_rs1_d,
    input  logic [RA_W-1:0]  i_rs2_d,
    input  logic [RA_W-1:0]  i_rd_d,
    output logic             o_valid_e,
    output logic [1:0]       o_result_src_e,
    output logic             o_mem_write_e,
    output logic             o_reg_write_e,
    output logic             o_jmp_e,
    output logic             o_branch_e,
    output logic [1:0]       o_alu_op_e,
    output logic             o_alu_src_e,
    output logic [2:0]       o_funct3_e,
    output logic             o_funct7b5_e,
    output logic [XLEN-1:0]  o_rd1_e,
    output logic [XLEN-1:0]  o_rd2_e,
    output logic [XLEN-1:0]  o_pc_e,
    output logic [XLEN-1:0]  o_pc_plus4_e,
    output logic [XLEN-1:0]  o_imm_ext_e,
    output logic [RA_W-1:0]  o_rs1_e,
    output logic [RA_W-1:0]  o_rs2_e,
    output logic [RA_W-1:0]  o_rd_e,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    localparam int DATA_W = 4 + 5 * XLEN;
    localparam int ADDR_W = 3 * RA_W;

    // ---------------- control bundle ----------------
    ctrl_t ctrl_in;
    ctrl_t ctrl_q;

    always_comb begin
        ctrl_in            = CTRL_NOP;
        ctrl_in.result_src = i_result_src_d;
        ctrl_in.mem_write  = i_mem_write_d;
        ctrl_in.reg_write  = i_reg_write_d;
        ctrl_in.jmp        = i_jmp_d;
        ctrl_in.branch     = i_branch_d;
        ctrl_in.alu_op     = i_alu_op_d;
        ctrl_in.alu_src    = i_alu_src_d;
    end

    pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_flush),
        .i_en  (i_en),
        .i_d   (ctrl_in),
        .o_q   (ctrl_q)
    );

    assign o_result_src_e = ctrl_q.result_src;
    assign o_mem_write_e  = ctrl_q.mem_write;
    assign o_reg_write_e  = ctrl_q.reg_write;
    assign o_jmp_e        = ctrl_q.jmp;
    assign o_branch_e     = ctrl_q.branch;
    assign o_alu_op_e     = ctrl_q.alu_op;
    assign o_alu_src_e    = ctrl_q.alu_src;

    // ---------------- datapath fields ----------------
    // Cleared on flush too, so a bubble never carries stale operands.
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_q;

    assign data_in = {i_funct3_d, i_funct7b5_d, i_rd1_d, i_rd2_d,
                      i_pc_d, i_pc_plus4_d, i_imm_ext_d};

    pipe_field_reg #(.W(DATA_W)) u_data_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_flush),
        .i_en  (i_en),
        .i_d   (data_in),
        .o_q   (data_q)
    );

    assign {o_funct3_e, o_funct7b5_e, o_rd1_e, o_rd2_e,
            o_pc_e, o_pc_plus4_e, o_imm_ext_e} = data_q;

    // ---------------- register addresses ----------------
    // Zeroed on flush so hazard/forwarding compares cannot hit on a bubble.
    logic [ADDR_W-1:0] addr_in;
    logic [ADDR_W-1:0] addr_q;

    assign addr_in = {i_rs1_d, i_rs2_d, i_rd_d};

    pipe_field_reg #(.W(ADDR_W)) u_addr_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_flush),
        .i_en  (i_en),
        .i_d   (addr_in),
        .o_q   (addr_q)
    );

    assign {o_rs1_e, o_rs2_e, o_rd_e} = addr_q;

    // ---------------- valid bit and bubble counter ----------------
    logic             valid_q;
    logic             valid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             squash;

    // A flush only counts when it kills a real instruction: the one that
    // would have been loaded (en=1) or the one being held (en=0).
    assign squash = i_flush & (i_en ? i_valid_d : valid_q);

    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (i_flush)
            valid_d = 1'b0;
        else if (i_en)
            valid_d = i_valid_d;
        if (squash)
            cnt_d = cnt_q + 1'b1;   // wraps naturally at 2^CNT_W
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_valid_e    = valid_q;
    assign o_bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic            valid;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            reg_write;
        logic            jmp;
        logic            branch;
        logic [1:0]      alu_op;
        logic            alu_src;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
    } bundle_t;

    logic    clk = 1'b0;
    logic    rst;
    logic    en;
    logic    flush;
    bundle_t in_b;
    bundle_t out_b;

    logic             o_valid_e, o_mem_write_e, o_reg_write_e, o_jmp_e;
    logic             o_branch_e, o_alu_src_e, o_funct7b5_e;
    logic [1:0]       o_result_src_e, o_alu_op_e;
    logic [2:0]       o_funct3_e;
    logic [XLEN-1:0]  o_rd1_e, o_rd2_e, o_pc_e, o_pc_plus4_e, o_imm_ext_e;
    logic [RA_W-1:0]  o_rs1_e, o_rs2_e, o_rd_e;
    logic [CNT_W-1:0] o_bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_en           (en),
        .i_flush        (flush),
        .i_valid_d      (in_b.valid),
        .i_result_src_d (in_b.result_src),
        .i_mem_write_d  (in_b.mem_write),
        .i_reg_write_d  (in_b.reg_write),
        .i_jmp_d        (in_b.jmp),
        .i_branch_d     (in_b.branch),
        .i_alu_op_d     (in_b.alu_op),
        .i_alu_src_d    (in_b.alu_src),
        .i_funct3_d     (in_b.funct3),
        .i_funct7b5_d   (in_b.funct7b5),
        .i_rd1_d        (in_b.rd1),
        .i_rd2_d        (in_b.rd2),
        .i_pc_d         (in_b.pc),
        .i_pc_plus4_d   (in_b.pc4),
        .i_imm_ext_d    (in_b.imm),
        .i_rs1_d        (in_b.rs1),
        .i_rs2_d        (in_b.rs2),
        .i_rd_d         (in_b.rd),
        .o_valid_e      (o_valid_e),
        .o_result_src_e (o_result_src_e),
        .o_mem_write_e  (o_mem_write_e),
        .o_reg_write_e  (o_reg_write_e),
        .o_jmp_e        (o_jmp_e),
        .o_branch_e     (o_branch_e),
        .o_alu_op_e     (o_alu_op_e),
        .o_alu_src_e    (o_alu_src_e),
        .o_funct3_e     (o_funct3_e),
        .o_funct7b5_e   (o_funct7b5_e),
        .o_rd1_e        (o_rd1_e),
        .o_rd2_e        (o_rd2_e),
        .o_pc_e         (o_pc_e),
        .o_pc_plus4_e   (o_pc_plus4_e),
        .o_imm_ext_e    (o_imm_ext_e),
        .o_rs1_e        (o_rs1_e),
        .o_rs2_e        (o_rs2_e),
        .o_rd_e         (o_rd_e),
        .o_bubble_cnt   (o_bubble_cnt)
    );

    assign out_b = {o_valid_e, o_result_src_e, o_mem_write_e, o_reg_write_e,
                    o_jmp_e, o_branch_e, o_alu_op_e, o_alu_src_e, o_funct3_e,
                    o_funct7b5_e, o_rd1_e, o_rd2_e, o_pc_e, o_pc_plus4_e,
                    o_imm_ext_e, o_rs1_e, o_rs2_e, o_rd_e};

    // Reference model: the execute-stage view is simply "the last bundle
    // accepted", an all-zero bundle after a flush, and a squash tally.
    bundle_t exp_b;
    int      exp_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_b   <= '0;
            exp_cnt <= 0;
        end else begin
            if (flush && (en ? in_b.valid : exp_b.valid))
                exp_cnt <= (exp_cnt + 1) % (1 << CNT_W);
            if (flush)
                exp_b <= '0;
            else if (en)
                exp_b <= in_b;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one edge and compare against the model on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("bundle", out_b, exp_b);
        chk("bubble_cnt", o_bubble_cnt, exp_cnt[CNT_W-1:0]);
    endtask

    task automatic rand_in();
        logic [223:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        in_b = r[$bits(bundle_t)-1:0];
    endtask

    initial begin
        // reset with all-ones inputs: outputs clear before any clock edge
        rst = 1'b1; en = 1'b1; flush = 1'b0;
        in_b = '1;
        #2;
        chk("reset_bundle", out_b, '0);
        chk("reset_cnt", o_bubble_cnt, 0);
        step();
        rst = 1'b0;

        // addi x3, imm 5
        in_b = '0; in_b.valid = 1; in_b.reg_write = 1; in_b.alu_src = 1;
        in_b.imm = 32'h0000_0005; in_b.rd = 5'd3;
        step();
        chk("addi_regw", o_reg_write_e, 1);
        chk("addi_alusrc", o_alu_src_e, 1);
        chk("addi_imm", o_imm_ext_e, 32'h5);
        chk("addi_rd", o_rd_e, 3);
        chk("addi_valid", o_valid_e, 1);

        // lw, then stall three cycles with changing inputs
        in_b = '0; in_b.valid = 1; in_b.result_src = 2'b01; in_b.reg_write = 1;
        in_b.rd = 5'd7; in_b.pc = 32'h100;
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_in();
            step();
        end
        chk("stall_rsrc", o_result_src_e, 2'b01);
        chk("stall_rd", o_rd_e, 7);
        chk("stall_pc", o_pc_e, 32'h100);
        chk("stall_cnt", o_bubble_cnt, 0);

        // sw then flush with beq on the inputs
        en = 1'b1;
        in_b = '0; in_b.valid = 1; in_b.mem_write = 1; in_b.rs1 = 5'd2; in_b.rs2 = 5'd9;
        step();
        chk("sw_memw", o_mem_write_e, 1);
        in_b = '0; in_b.valid = 1; in_b.branch = 1; in_b.alu_op = 2'b01; in_b.rd = 5'd12;
        flush = 1'b1;
        step();
        chk("flush_memw", o_mem_write_e, 0);
        chk("flush_branch", o_branch_e, 0);
        chk("flush_rd", o_rd_e, 0);
        chk("flush_valid", o_valid_e, 0);
        chk("flush_cnt", o_bubble_cnt, 1);

        // flush with en=0 over a held valid instruction, then flush again
        flush = 1'b0; en = 1'b1; rand_in(); in_b.valid = 1;
        step();
        flush = 1'b1; en = 1'b0; in_b.valid = 0;
        step();
        chk("flushhold_valid", o_valid_e, 0);
        chk("flushhold_cnt", o_bubble_cnt, 2);
        in_b.valid = 1;   // ignored: en=0, and held value is now a bubble
        step();
        chk("flush2_cnt", o_bubble_cnt, 2);

        // jal held, then async reset between edges
        flush = 1'b0; en = 1'b1;
        in_b = '0; in_b.valid = 1; in_b.jmp = 1; in_b.result_src = 2'b10;
        in_b.reg_write = 1; in_b.rd = 5'd1; in_b.pc = 32'h200; in_b.pc4 = 32'h204;
        step();
        chk("jal_jmp", o_jmp_e, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_bundle", out_b, '0);
        chk("async_cnt", o_bubble_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // counter wrap: squash 16 real instructions
        for (int i = 0; i < 16; i++) begin
            flush = 1'b0; en = 1'b1; rand_in(); in_b.valid = 1;
            step();
            flush = 1'b1;
            step();
            if (i == 14) chk("wrap_cnt15", o_bubble_cnt, 4'hF);
        end
        chk("wrap_cnt0", o_bubble_cnt, 0);

        // randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 400; i++) begin
            rand_in();
            en    = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
